// File: rtl/router_pkt_tx.sv
// Store-and-forward packet transmitter toward a router port: buffers the payload, then sends header, payload and parity.
// Optional ROUTER_TX_PARITY_INJ_EN adds inj_parity_err, which inverts the parity byte of the packet it is latched with.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; rejects invalid address/length
// LOAD    | accepting pay_len payload bytes into the buffer
// HEADER  | driving {pay_len, dest_addr}
// PAYLOAD | driving buffered bytes in order
// PARITY  | driving XOR of header and payload, pkt_valid low
// CHECK   | three cycles watching the router err flag
module router_pkt_tx (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] pay_len,
  input  logic [7:0] pay_data,
  input  logic       pay_valid,
  output logic       pay_ready,
  input  logic       busy,
  input  logic       err,
`ifdef ROUTER_TX_PARITY_INJ_EN
  input  logic       inj_parity_err,
`endif
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_busy,
  output logic       done,
  output logic       err_seen,
  output logic       cfg_reject
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_CHECK
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [5:0] len_q, len_d;
  logic [5:0] idx_q, idx_d;
  logic [7:0] parity_q, parity_d;
  logic [1:0] chk_q, chk_d;
  logic       err_seen_q, err_seen_d;
  logic       cfg_reject_q, cfg_reject_d;
  logic       inj_q, inj_d;

  logic [7:0] pay_mem [64];
  logic       mem_we;
  logic [7:0] hdr_byte;
  logic [7:0] parity_byte;
  logic [7:0] mem_rd;
  logic       idx_last;

  assign hdr_byte    = {len_q, addr_q};
  assign mem_rd      = pay_mem[idx_q];
  assign idx_last    = (idx_q == (len_q - 6'd1));
  assign parity_byte = parity_q ^ {8{inj_q}};
  assign mem_we      = (state_q == S_LOAD) && pay_valid;

`ifdef ROUTER_TX_PARITY_INJ_EN
  logic inj_in;
  assign inj_in = inj_parity_err;
`else
  logic inj_in;
  assign inj_in = 1'b0;
`endif

  // Payload storage needs no reset: every slot read is written in LOAD first.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      pay_mem[idx_q] <= pay_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      addr_q       <= 2'd0;
      len_q        <= 6'd0;
      idx_q        <= 6'd0;
      parity_q     <= 8'd0;
      chk_q        <= 2'd0;
      err_seen_q   <= 1'b0;
      cfg_reject_q <= 1'b0;
      inj_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      parity_q     <= parity_d;
      chk_q        <= chk_d;
      err_seen_q   <= err_seen_d;
      cfg_reject_q <= cfg_reject_d;
      inj_q        <= inj_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    idx_d        = idx_q;
    parity_d     = parity_q;
    chk_d        = chk_q;
    err_seen_d   = err_seen_q;
    cfg_reject_d = 1'b0;
    inj_d        = inj_q;
    pay_ready    = 1'b0;
    data_out     = 8'd0;
    pkt_valid    = 1'b0;
    done         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((dest_addr == 2'd3) || (pay_len == 6'd0)) begin
            cfg_reject_d = 1'b1;
          end else begin
            addr_d     = dest_addr;
            len_d      = pay_len;
            idx_d      = 6'd0;
            err_seen_d = 1'b0;
            inj_d      = inj_in;
            state_d    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        pay_ready = 1'b1;
        if (pay_valid) begin
          if (idx_last) begin
            idx_d    = 6'd0;
            parity_d = hdr_byte;
            state_d  = S_HEADER;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      S_HEADER: begin
        data_out  = hdr_byte;
        pkt_valid = 1'b1;
        if (!busy) begin
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        data_out  = mem_rd;
        pkt_valid = 1'b1;
        if (!busy) begin
          parity_d = parity_q ^ mem_rd;
          if (idx_last) begin
            idx_d   = 6'd0;
            state_d = S_PARITY;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      S_PARITY: begin
        data_out = parity_byte;
        if (!busy) begin
          chk_d   = 2'd2;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (err) begin
          err_seen_d = 1'b1;
        end
        // Down-counter from 2: terminal count marks the third CHECK cycle.
        if (chk_q == 2'd0) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          chk_d = chk_q - 2'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx_busy    = (state_q != S_IDLE);
  assign err_seen   = err_seen_q;
  assign cfg_reject = cfg_reject_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed self-checking bench for router_pkt_tx; stimulus and expected bytes are hand-computed.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dest_addr = 2'd0;
  logic [5:0] pay_len = 6'd0;
  logic [7:0] pay_data = 8'd0;
  logic       pay_valid = 1'b0;
  logic       busy = 1'b0;
  logic       err = 1'b0;
  logic       pay_ready;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_busy;
  logic       done;
  logic       err_seen;
  logic       cfg_reject;
`ifdef ROUTER_TX_PARITY_INJ_EN
  logic       inj_cfg = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0] pl [64];

  router_pkt_tx dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .dest_addr  (dest_addr),
    .pay_len    (pay_len),
    .pay_data   (pay_data),
    .pay_valid  (pay_valid),
    .pay_ready  (pay_ready),
    .busy       (busy),
    .err        (err),
`ifdef ROUTER_TX_PARITY_INJ_EN
    .inj_parity_err (inj_cfg),
`endif
    .data_out   (data_out),
    .pkt_valid  (pkt_valid),
    .tx_busy    (tx_busy),
    .done       (done),
    .err_seen   (err_seen),
    .cfg_reject (cfg_reject)
  );

  always #5 clk = ~clk;

  // Full packet: start, load, transmit (optional stall / stray start / err), check phase.
  task automatic send_packet(input logic [1:0] a, input logic [5:0] n, input int stall_k,
                             input int stall_n, input int err_c, input logic [7:0] exp_par,
                             input logic exp_err, input int ign_k);
    logic [7:0] exp_b;
    logic       exp_v;
    int         reps;
    @(negedge clk);
    start = 1'b1; dest_addr = a; pay_len = n;
    @(negedge clk);
    start = 1'b0;
    total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL load_tx_busy got=%b want=1", tx_busy); end
    total++; if (pay_ready !== 1'b1) begin bad++; $display("FAIL load_pay_ready got=%b want=1", pay_ready); end
    total++; if (err_seen !== 1'b0) begin bad++; $display("FAIL load_err_seen_clear got=%b want=0", err_seen); end
    for (int i = 0; i < int'(n); i++) begin
      pay_valid = 1'b1; pay_data = pl[i];
      @(negedge clk);
    end
    pay_valid = 1'b0;
    for (int k = 0; k <= int'(n) + 1; k++) begin
      if (k == 0) exp_b = {n, a};
      else if (k <= int'(n)) exp_b = pl[k-1];
      else exp_b = exp_par;
      exp_v = (k <= int'(n));
      reps = (k == stall_k) ? stall_n + 1 : 1;
      for (int r = 0; r < reps; r++) begin
        busy = (r < reps - 1);
        if (k == ign_k && r == 0) begin start = 1'b1; dest_addr = 2'd0; pay_len = 6'd1; end
        else start = 1'b0;
        total++; if (data_out !== exp_b) begin bad++; $display("FAIL byte%0d_rep%0d data_out got=%h want=%h", k, r, data_out, exp_b); end
        total++; if (pkt_valid !== exp_v) begin bad++; $display("FAIL byte%0d_rep%0d pkt_valid got=%b want=%b", k, r, pkt_valid, exp_v); end
        total++; if (pay_ready !== 1'b0) begin bad++; $display("FAIL byte%0d pay_ready got=%b want=0", k, pay_ready); end
        @(negedge clk);
      end
    end
    busy = 1'b0; start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      err = (c == err_c);
      total++; if (data_out !== 8'h00) begin bad++; $display("FAIL check%0d data_out got=%h want=00", c, data_out); end
      total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL check%0d pkt_valid got=%b want=0", c, pkt_valid); end
      total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL check%0d tx_busy got=%b want=1", c, tx_busy); end
      total++; if (done !== (c == 2)) begin bad++; $display("FAIL check%0d done got=%b want=%b", c, done, (c == 2)); end
      @(negedge clk);
    end
    err = 1'b0;
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL end_tx_busy got=%b want=0", tx_busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL end_done got=%b want=0", done); end
    total++; if (err_seen !== exp_err) begin bad++; $display("FAIL end_err_seen got=%b want=%b", err_seen, exp_err); end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    #12;
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL rst_tx_busy got=%b want=0", tx_busy); end
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL rst_pkt_valid got=%b want=0", pkt_valid); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_data_out got=%h want=00", data_out); end
    total++; if (pay_ready !== 1'b0) begin bad++; $display("FAIL rst_pay_ready got=%b want=0", pay_ready); end
    total++; if ({done, err_seen, cfg_reject} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {done, err_seen, cfg_reject}); end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reject(input logic [1:0] a, input logic [5:0] n);
    @(negedge clk);
    start = 1'b1; dest_addr = a; pay_len = n;
    @(negedge clk);
    start = 1'b0;
    total++; if (cfg_reject !== 1'b1) begin bad++; $display("FAIL rej_pulse a=%0d n=%0d got=%b want=1", a, n, cfg_reject); end
    total++; if (pay_ready !== 1'b0) begin bad++; $display("FAIL rej_pay_ready got=%b want=0", pay_ready); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL rej_tx_busy got=%b want=0", tx_busy); end
    @(negedge clk);
    total++; if (cfg_reject !== 1'b0) begin bad++; $display("FAIL rej_one_cycle got=%b want=0", cfg_reject); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL rej_stay_idle got=%b want=0", tx_busy); end
  endtask

  task automatic test_basic;
    pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
    send_packet(2'd1, 6'd3, -1, 0, -1, 8'hDD, 1'b0, -1);
  endtask

  task automatic test_stall;
    pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
    send_packet(2'd1, 6'd3, 2, 3, -1, 8'hDD, 1'b0, 1);
    @(negedge clk);
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL stray_start_ignored got=%b want=0", tx_busy); end
  endtask

  task automatic test_err_seen;
    pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
    send_packet(2'd1, 6'd3, -1, 0, 1, 8'hDD, 1'b1, -1);
    @(negedge clk);
    total++; if (err_seen !== 1'b1) begin bad++; $display("FAIL err_seen_hold got=%b want=1", err_seen); end
    test_reject(2'd3, 6'd2);
    total++; if (err_seen !== 1'b1) begin bad++; $display("FAIL err_seen_after_reject got=%b want=1", err_seen); end
    send_packet(2'd1, 6'd3, -1, 0, -1, 8'hDD, 1'b0, -1);
  endtask

  task automatic test_long;
    for (int i = 0; i < 63; i++) pl[i] = 8'(i);
    send_packet(2'd2, 6'd63, -1, 0, -1, 8'hC1, 1'b0, -1);
  endtask

  task automatic test_reset_mid;
    pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
    @(negedge clk);
    start = 1'b1; dest_addr = 2'd1; pay_len = 6'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pay_valid = 1'b1; pay_data = pl[i];
      @(negedge clk);
    end
    pay_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (data_out !== 8'hB2) begin bad++; $display("FAIL mid_pre_reset got=%h want=b2", data_out); end
    resetn = 1'b0;
    #1;
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL mid_rst_data_out got=%h want=00", data_out); end
    total++; if (pkt_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_pkt_valid got=%b want=0", pkt_valid); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_tx_busy got=%b want=0", tx_busy); end
    @(negedge clk);
    resetn = 1'b1;
    pl[0] = 8'h5A;
    send_packet(2'd0, 6'd1, -1, 0, -1, 8'h5E, 1'b0, -1);
  endtask

`ifdef ROUTER_TX_PARITY_INJ_EN
  task automatic test_inject;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
    inj_cfg = 1'b1;
    send_packet(2'd1, 6'd3, -1, 0, 0, 8'h22, 1'b1, -1);
    inj_cfg = 1'b0;
    send_packet(2'd1, 6'd3, -1, 0, -1, 8'hDD, 1'b0, -1);
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_reject(2'd3, 6'd3);
    test_reject(2'd1, 6'd0);
    test_stall;
    test_err_seen;
    test_long;
    test_reset_mid;
`ifdef ROUTER_TX_PARITY_INJ_EN
    test_inject;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL provide: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide: resetn  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide: start  in  1  packet request, sampled in IDLE only.
REQ-004 SHALL provide: dest_addr  in  2  destination port; 0..2 valid, 3 invalid.
REQ-005 SHALL provide: pay_len  in  6  payload byte count; 1..63 valid, 0 invalid.
REQ-006 SHALL provide: pay_data  in  8 / pay_valid  in  1 / pay_ready  out  1  upstream payload handshake.
REQ-007 SHALL provide: busy  in  1  router stall; err  in  1  router parity-error flag.
REQ-008 SHALL provide: data_out  out  8 / pkt_valid  out  1  router-side packet byte and valid.
REQ-009 SHALL provide: tx_busy  out  1 (high whenever not IDLE), done  out  1 (1-cycle pulse), err_seen  out  1, cfg_reject  out  1 (1-cycle pulse).

Function
REQ-010 SHALL implement states IDLE, LOAD, HEADER, PAYLOAD, PARITY, CHECK; store-and-forward via a 64x8 internal payload buffer.
REQ-011 IDLE: start with dest_addr==3 or pay_len==0 SHALL pulse cfg_reject the next cycle and remain IDLE; otherwise latch addr/len, clear err_seen, go to LOAD.
REQ-012 LOAD: pay_ready SHALL be 1; each pay_valid&&pay_ready cycle writes pay_data to the next buffer slot; after the pay_len-th byte, go to HEADER. pay_ready SHALL be 0 in every other state.
REQ-013 HEADER: data_out={pay_len,dest_addr}, pkt_valid=1; running parity initialised to the header byte.
REQ-014 A byte is "sent" in any cycle of HEADER/PAYLOAD/PARITY with busy==0; on a sent cycle, state/index advance; with busy==1, data_out, pkt_valid, and state SHALL hold unchanged.
REQ-015 PAYLOAD: data_out=buffer[i], pkt_valid=1, i=0..pay_len-1 in order; parity ^= each sent byte; after byte pay_len-1 is sent go to PARITY.
REQ-016 PARITY: data_out=XOR of header and all payload bytes, pkt_valid=0, exactly one sent cycle, then CHECK.
REQ-017 CHECK: lasts exactly 3 cycles; err==1 in any of them SHALL set err_seen (held until next accepted start); on the last CHECK cycle pulse done and return to IDLE.
REQ-018 No gaps: pkt_valid SHALL stay 1 continuously from HEADER through the last payload byte; start while not IDLE SHALL be ignored.
REQ-019 In IDLE/LOAD/CHECK data_out SHALL be 0 and pkt_valid 0.

Reset
REQ-020 resetn low SHALL immediately force IDLE, data_out=0, pkt_valid=0, pay_ready=0, tx_busy=0, done=0, err_seen=0, cfg_reject=0, counters and parity=0, including mid-packet.
REQ-021 Buffer contents SHALL NOT require reset; the first start after reset release SHALL operate normally.

Configuration
REQ-022 With ROUTER_TX_PARITY_INJ_EN defined, input inj_parity_err (1 bit) SHALL exist; if high on the accepted start cycle, the PARITY byte is bitwise-inverted for that packet.
REQ-023 Without ROUTER_TX_PARITY_INJ_EN, inj_parity_err SHALL be absent and parity is always correct.

Verification
REQ-024 addr=1,len=3, payload A1,B2,C3, busy=0 -> data_out 0D,A1,B2,C3 with pkt_valid=1 on consecutive cycles, then DD with pkt_valid=0, done pulse 3 cycles later, err_seen=0.
REQ-025 Same packet, busy=1 for 3 cycles while B2 is driven -> B2 with pkt_valid=1 held for 4 cycles, then C3, parity DD unchanged.
REQ-026 start with dest_addr=3 (and separately pay_len=0) -> cfg_reject for 1 cycle, pay_ready stays 0, tx_busy stays 0.
REQ-027 addr=2,len=63, payload 00..3E -> header FE, 63 payload bytes in order, no pkt_valid gap, parity = FE XOR all payload bytes.
REQ-028 resetn low during the 2nd payload byte -> data_out=0, pkt_valid=0 in the same cycle; after release, a new addr=0,len=1 packet completes correctly.
REQ-029 ROUTER_TX_PARITY_INJ_EN, inj_parity_err=1, first packet -> parity byte 22; router model asserts err -> err_seen=1 until next start.
